ysyx_210247_trap_ctrl: RTL and testbench

YSYX_210247_TRAP_CTRL -- requirements
Module: ysyx_210247_trap_ctrl

---
 rtl/ysyx_210247_trap_ctrl.sv | 144 ++++++++++++++
 tb/tb_ysyx_210247_trap_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210247_trap_ctrl.sv
// Trap/mret commit controller: detects ecall, mret and timer interrupts at commit,
// waits for outstanding memory traffic, strobes the CSR update, then redirects fetch.
module ysyx_210247_trap_ctrl #(
  parameter int          XLEN      = 64,
  parameter int unsigned MRET_CODE = 666
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] commit_next_pc,
  input  logic            commit_ecall,
  input  logic            commit_mret,
  input  logic            timer_irq,
  input  logic            mem_busy,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [XLEN-1:0] exc_type,
  output logic [XLEN-1:0] exc_addr,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            stall
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, FLUSH, REDIRECT} state_t;

  localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);
  localparam logic [XLEN-1:0] MRET_CAUSE  = XLEN'(MRET_CODE);
  localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);

  state_t          state;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] addr_q;
  logic            mret_q;

  logic            irq_pending;
  logic            ev_ecall;
  logic            ev_mret;
  logic            ev_irq;
  logic            ev_any;
  logic [XLEN-1:0] ev_cause;
  logic [XLEN-1:0] ev_addr;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] flush_target;
  logic            unused_csr_bits;

  assign unused_csr_bits = ^{mstatus_i, mie_i};

  // A deferred interrupt needs no bookkeeping: timer_irq is level-sensitive, so it
  // is simply seen again at the next commit after the ecall/mret completes.
  assign irq_pending = timer_irq & mstatus_i[3] & mie_i[7];
  assign ev_ecall    = commit_valid & commit_ecall;
  assign ev_mret     = commit_valid & commit_mret & ~commit_ecall;
  assign ev_irq      = commit_valid & irq_pending & ~commit_ecall & ~commit_mret;
  assign ev_any      = ev_ecall | ev_mret | ev_irq;

  always_comb begin
    ev_cause = ECALL_CAUSE;
    ev_addr  = commit_pc;
    if (ev_mret) begin
      ev_cause = MRET_CAUSE;
    end else if (ev_irq) begin
      ev_cause = IRQ_CAUSE;
      ev_addr  = commit_next_pc;
    end
  end

  // Vectored mode only applies to interrupts; the add wraps at XLEN bits.
  assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
  always_comb begin
    flush_target = tvec_base;
    if (mret_q)
      flush_target = mepc_i;
    else if (mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
      flush_target = tvec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cause_q        <= '0;
      addr_q         <= '0;
      mret_q         <= 1'b0;
      exc_type       <= '0;
      exc_addr       <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_any) begin
            cause_q <= ev_cause;
            addr_q  <= ev_addr;
            mret_q  <= ev_mret;
            stall   <= 1'b1;
            if (mem_busy) begin
              state <= WAIT_MEM;
            end else begin
              state    <= FLUSH;
              flush    <= 1'b1;
              exc_type <= ev_cause;
              exc_addr <= ev_addr;
            end
          end
        end
        WAIT_MEM: begin
          if (!mem_busy) begin
            state    <= FLUSH;
            flush    <= 1'b1;
            exc_type <= cause_q;
            exc_addr <= addr_q;
          end
        end
        FLUSH: begin
          state          <= REDIRECT;
          flush          <= 1'b0;
          exc_type       <= '0;
          exc_addr       <= '0;
          redirect_valid <= 1'b1;
          redirect_pc    <= flush_target;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall          <= 1'b0;
            cause_q        <= '0;
            addr_q         <= '0;
            mret_q         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210247_trap_ctrl.sv
// Self-checking bench for ysyx_210247_trap_ctrl: directed scenarios then randomized
// transactions checked against a transaction-level reference model.
module tb_ysyx_210247_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] commit_next_pc;
  logic        commit_ecall;
  logic        commit_mret;
  logic        timer_irq;
  logic        mem_busy;
  logic [63:0] mstatus_i;
  logic [63:0] mie_i;
  logic [63:0] mtvec_i;
  logic [63:0] mepc_i;
  logic [63:0] exc_type;
  logic [63:0] exc_addr;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        stall;

  int checks = 0;
  int errors = 0;

  ysyx_210247_trap_ctrl #(.XLEN(64), .MRET_CODE(666)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_next_pc(commit_next_pc),
    .commit_ecall(commit_ecall), .commit_mret(commit_mret),
    .timer_irq(timer_irq), .mem_busy(mem_busy),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .exc_type(exc_type), .exc_addr(exc_addr), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Junk commit traffic while busy; the controller must ignore it.
  task automatic scramble_commit();
    commit_valid   = 1'($urandom);
    commit_ecall   = 1'($urandom);
    commit_mret    = 1'($urandom);
    commit_pc      = {$urandom, $urandom};
    commit_next_pc = {$urandom, $urandom};
  endtask

  // Reference model: what a retiring instruction should cause, from the ISA rules.
  function automatic void model(
    input logic v, input logic ec, input logic mr, input logic irq,
    input logic [63:0] ms, input logic [63:0] me, input logic [63:0] pc, input logic [63:0] npc,
    input logic [63:0] tvec, input logic [63:0] epc,
    output logic hit, output logic [63:0] cause, output logic [63:0] addr, output logic [63:0] target);
    logic [63:0] base;
    logic        irq_on;
    base   = tvec - (tvec % 64'd4);
    irq_on = irq && ms[3] && me[7];
    hit    = 1'b1;
    cause  = 64'd0;
    addr   = 64'd0;
    target = 64'd0;
    if (!v) begin
      hit = 1'b0;
    end else if (ec) begin
      cause = 64'd11; addr = pc; target = base;
    end else if (mr) begin
      cause = 64'd666; addr = pc; target = epc;
    end else if (irq_on) begin
      cause  = 64'h8000_0000_0000_0007;
      addr   = npc;
      target = ((tvec % 64'd4) == 64'd1) ? base + 64'd4 * (cause % 64'd64) : base;
    end else begin
      hit = 1'b0;
    end
  endfunction

  task automatic run_txn(
    input string tag, input logic v, input logic ec, input logic mr, input logic irq,
    input logic [63:0] ms, input logic [63:0] me, input logic [63:0] pc, input logic [63:0] npc,
    input logic [63:0] tvec, input logic [63:0] epc, input int busy, input int rdy_delay);
    logic        hit;
    logic [63:0] cause, addr, target;
    model(v, ec, mr, irq, ms, me, pc, npc, tvec, epc, hit, cause, addr, target);
    commit_valid = v; commit_ecall = ec; commit_mret = mr; timer_irq = irq;
    mstatus_i = ms; mie_i = me; commit_pc = pc; commit_next_pc = npc;
    mtvec_i = tvec; mepc_i = epc; mem_busy = (busy > 0);
    step();
    scramble_commit();
    if (!hit) begin
      chk({tag, ".idle_stall"}, 64'(stall), 64'd0);
      chk({tag, ".idle_flush"}, 64'(flush), 64'd0);
      commit_valid = 1'b0;
      return;
    end
    for (int i = 0; i < busy; i++) begin
      chk({tag, ".wait_stall"}, 64'(stall), 64'd1);
      chk({tag, ".wait_flush"}, 64'(flush), 64'd0);
      mem_busy = (i < busy - 1);
      step();
      scramble_commit();
    end
    chk({tag, ".flush"}, 64'(flush), 64'd1);
    chk({tag, ".exc_type"}, exc_type, cause);
    chk({tag, ".exc_addr"}, exc_addr, addr);
    chk({tag, ".flush_rv"}, 64'(redirect_valid), 64'd0);
    step();
    scramble_commit();
    for (int d = 0; d <= rdy_delay; d++) begin
      redirect_ready = (d == rdy_delay);
      chk({tag, ".rv"}, 64'(redirect_valid), 64'd1);
      chk({tag, ".rpc"}, redirect_pc, target);
      chk({tag, ".rd_flush"}, 64'(flush), 64'd0);
      chk({tag, ".rd_etype"}, exc_type, 64'd0);
      chk({tag, ".rd_stall"}, 64'(stall), 64'd1);
      step();
      scramble_commit();
    end
    redirect_ready = 1'b0;
    commit_valid   = 1'b0;
    chk({tag, ".done_stall"}, 64'(stall), 64'd0);
    chk({tag, ".done_rv"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_next_pc = '0;
    commit_ecall = 1'b0; commit_mret = 1'b0; timer_irq = 1'b0; mem_busy = 1'b0;
    mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0; redirect_ready = 1'b0;
    step(); step();
    chk("reset.stall", 64'(stall), 64'd0);
    chk("reset.flush", 64'(flush), 64'd0);
    chk("reset.rv", 64'(redirect_valid), 64'd0);
    chk("reset.exc_type", exc_type, 64'd0);
    chk("reset.exc_addr", exc_addr, 64'd0);
    rst = 1'b0;
    step();

    run_txn("ecall", 1, 1, 0, 0, 0, 0, 64'h8000_0010, 64'h8000_0014, 64'h8000_1000, 0, 0, 0);
    run_txn("mret", 1, 0, 1, 0, 0, 0, 64'h8000_0020, 64'h8000_0024, 64'h8000_1000, 64'h8000_0044, 0, 0);
    run_txn("irq_vec", 1, 0, 0, 1, 64'h8, 64'h80, 64'h8000_0100, 64'h8000_0104, 64'h8000_2001, 0, 0, 0);
    run_txn("ecall_busy5", 1, 1, 0, 0, 0, 0, 64'h8000_0030, 64'h8000_0034, 64'h8000_1000, 0, 5, 0);
    run_txn("ready_late", 1, 1, 0, 0, 0, 0, 64'h8000_0040, 64'h8000_0044, 64'h8000_1002, 0, 0, 3);
    run_txn("irq_masked", 1, 0, 0, 1, 64'h0, 64'h80, 64'h8000_0050, 64'h8000_0054, 64'h8000_1000, 0, 0, 0);
    run_txn("ecall_w_irq", 1, 1, 0, 1, 64'h8, 64'h80, 64'h8000_0060, 64'h8000_0064, 64'h8000_2001, 0, 0, 0);
    run_txn("irq_after", 1, 0, 0, 1, 64'h8, 64'h80, 64'h8000_0064, 64'h8000_0068, 64'h8000_2001, 0, 0, 0);
    run_txn("irq_wrap", 1, 0, 0, 1, 64'h8, 64'h80, 64'h10, 64'h14, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 1);
    run_txn("no_valid", 0, 1, 1, 1, 64'h8, 64'h80, 64'h10, 64'h14, 64'h100, 0, 0, 0);

    // Reset in the middle of a memory wait discards the pending trap.
    commit_valid = 1'b1; commit_ecall = 1'b1; commit_mret = 1'b0; timer_irq = 1'b0;
    commit_pc = 64'h8000_0070; mem_busy = 1'b1;
    step();
    commit_valid = 1'b0;
    chk("rstwait.stall_before", 64'(stall), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_busy = 1'b0;
    chk("rstwait.stall", 64'(stall), 64'd0);
    chk("rstwait.flush", 64'(flush), 64'd0);
    step();
    chk("rstwait.flush_later", 64'(flush), 64'd0);
    run_txn("post_rst", 1, 1, 0, 0, 0, 0, 64'h8000_0080, 64'h8000_0084, 64'h8000_1000, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn("rand", 1'($urandom), ($urandom % 4) == 0, ($urandom % 4) == 0, 1'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom % 4), int'($urandom % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
